// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, WIDTH+2 cycle latency.
// Define ITER_DIVIDER_EARLY_EXIT_EN to skip iteration when |divisor| > |dividend|.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_op,
  input  logic               div_signed,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] q, r, d;
  logic           q_neg, r_neg, zero;

  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic           a_s, b_s, accept, skip, ge;
  logic [WIDTH:0] rs, diff;

  always_comb begin
    a_s    = div_signed & dividend[WIDTH-1];
    b_s    = div_signed & divisor[WIDTH-1];
    a_mag  = a_s ? -dividend : dividend;
    b_mag  = b_s ? -divisor : divisor;
    accept = (state == IDLE || state == DONE)
             && div_op && !cancel;
`ifdef ITER_DIVIDER_EARLY_EXIT_EN
    skip   = (b_mag != '0) && (b_mag > a_mag);
`else
    skip   = 1'b0;
`endif
    rs     = {r, q[WIDTH-1]};
    ge     = rs >= {1'b0, d};
    diff   = rs - {1'b0, d};
    // zero divisor leaves q all-ones and r = |dividend|
    q_fix  = zero ? '1 : (q_neg ? -q : q);
    r_fix  = r_neg ? -r : r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero        <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            q     <= skip ? '0 : a_mag;
            r     <= skip ? a_mag : '0;
            d     <= b_mag;
            q_neg <= a_s ^ b_s;
            r_neg <= a_s;
            zero  <= (divisor == '0);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= skip ? FIX : CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            q   <= {q[WIDTH-2:0], ge};
            r   <= ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (cancel) begin
            state <= IDLE;
          end else begin
            result      <= {q_fix, r_fix};
            div_by_zero <= zero;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port div_op  input  1  start request; sampled only when idle or in DONE.
REQ-005 SHALL have port div_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with div_op.
REQ-006 SHALL have port cancel  input  1  abort the in-flight operation.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; sampled with div_op.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; sampled with div_op.
REQ-009 SHALL have port result  output  2*WIDTH  {quotient, remainder}, quotient in upper WIDTH bits.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port div_by_zero  output  1  result came from zero divisor; valid with done.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; busy = (CALC or FIX); done = (DONE).
REQ-014 SHALL accept an operation on an edge where state is IDLE or DONE, div_op=1 and cancel=0; acceptance registers magnitudes of operands (absolute values when div_signed=1), quotient sign (dividend MSB xor divisor MSB, signed only) and remainder sign (dividend MSB, signed only), then enters CALC.
REQ-015 SHALL perform one radix-2 restoring step per cycle in CALC, exactly WIDTH steps, then enter FIX.
REQ-016 SHALL in FIX apply two's-complement negation to quotient/remainder per registered signs, load result and div_by_zero, and enter DONE.
REQ-017 SHALL leave DONE after one cycle: to CALC if a new operation is accepted that edge, else IDLE.
REQ-018 SHALL assert done exactly WIDTH+2 rising edges after the acceptance edge (34 for WIDTH=32), absent early exit.
REQ-019 SHALL hold result and div_by_zero stable from FIX load until the next FIX load, including across IDLE.
REQ-020 SHALL, for divisor=0, produce quotient all-ones, remainder = original dividend bits, div_by_zero=1, at normal latency, regardless of div_signed.
REQ-021 SHALL, for signed most-negative / -1, produce quotient = most-negative value, remainder 0, div_by_zero=0.
REQ-022 SHALL treat cancel=1 in CALC or FIX as abort: next state IDLE, no done, result and div_by_zero unchanged.
REQ-023 SHALL give cancel priority over div_op on the same edge; cancel in IDLE or DONE has no effect other than blocking acceptance.
REQ-024 SHALL ignore div_op while busy=1.

Reset
REQ-025 SHALL on rst=1 at an edge force IDLE and clear result, done, busy, div_by_zero and all internal registers to 0, including mid-operation; rst has priority over all inputs.

Configuration
REQ-026 SHALL, with macro ITER_DIVIDER_EARLY_EXIT_EN defined, on acceptance with nonzero divisor magnitude strictly greater than dividend magnitude, skip CALC: enter FIX with quotient 0, remainder = dividend magnitude; done 2 edges after acceptance.
REQ-027 SHALL, with ITER_DIVIDER_EARLY_EXIT_EN undefined, always traverse CALC; results identical in both builds, only latency differs.

Verification
REQ-028 Unsigned 100/7, WIDTH=32 -> quotient 14, remainder 2, done pulse exactly 34 edges after acceptance, busy high 33 cycles.
REQ-029 Signed -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-030 Divisor 0, dividend 5 (signed and unsigned) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1.
REQ-031 cancel asserted 10 cycles into CALC -> busy low next cycle, no done, prior result held; new op accepted next cycle completes correctly.
REQ-032 Unsigned 3/10 -> quotient 0, remainder 3; done at +2 edges with ITER_DIVIDER_EARLY_EXIT_EN, +34 without.
REQ-033 Back-to-back: div_op held high during DONE -> second op accepted that edge, done pulses 34 edges apart; rst mid-CALC -> all outputs 0 next cycle.
